// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit machine.
// Decodes time-domain strobes from state, with watchdog and retire counter.
module instr_sequencer #(
   parameter logic [3:0]  HALT_OP     = 4'hF,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       opcode,
   input  logic             memRead,
   input  logic             memWrite,
   input  logic             regWrite,
   input  logic             jctrl,
   input  logic             jrctrl,
   input  logic             jalctrl,
   input  logic             beqctrl,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             resume,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             pc_load,
   output logic [1:0]       pc_src,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             alu_en,
   output logic             reg_we,
   output logic [2:0]       state,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_e;

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             at_limit;
   logic             waiting;
   logic             retire;

   always_comb begin
      state_d  = state_q;
      at_limit = (wait_q == LIMIT);
      case (state_q)
         S_FETCH: begin
            if (mem_ready)     state_d = S_DECODE;
            else if (at_limit) state_d = S_ERR;
         end
         S_DECODE: begin
            state_d = (opcode == HALT_OP) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            if (memRead | memWrite)     state_d = S_MEM;
            else if (regWrite | jalctrl) state_d = S_WB;
            else                         state_d = S_FETCH;
         end
         S_MEM: begin
            if (mem_ready)     state_d = memRead ? S_WB : S_FETCH;
            else if (at_limit) state_d = S_ERR;
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  if (resume) state_d = S_FETCH;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   // A request that stays in place has seen no mem_ready, so it keeps counting.
   always_comb begin
      waiting = (state_q == S_FETCH) || (state_q == S_MEM);
      wait_d  = (waiting && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
   end

   always_comb begin
      retire = (state_d == S_FETCH) &&
               ((state_q == S_EXEC) || (state_q == S_MEM) ||
                (state_q == S_WB)   || (state_q == S_HALT));
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= 8'd0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   // Strobes are gated by rst_n so a reset drops them without a clock edge.
   always_comb begin
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      pc_src   = 2'b00;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      alu_en   = 1'b0;
      reg_we   = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               ir_load  = mem_ready;
               pc_inc   = mem_ready;
            end
            S_EXEC: begin
               alu_en  = 1'b1;
               pc_load = jctrl | jalctrl | jrctrl | (beqctrl & zero);
               if (jrctrl)       pc_src = 2'b01;
               else if (beqctrl) pc_src = 2'b10;
               else              pc_src = 2'b00;
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = memWrite;
            end
            S_WB:    reg_we = 1'b1;
            default: ;
         endcase
      end
   end

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign error   = (state_q == S_ERR);
   assign retired = retired_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit machine.
- Drives the time-domain enables that the combinational `ctrl` decoder cannot supply on its own: instruction-register load, PC update, memory request handshake, register-file write strobe.
- Consumes the decoder's outputs for the current 4-bit opcode.
- Adds halt handling, a memory-wait watchdog and a retired-instruction counter.

Parameters:
- HALT_OP, 4'hF, opcode that enters HALT after decode.
- MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before ERR (range 2..255).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  instructions[3:0] from instruction register
- memRead  in  1  from ctrl decoder
- memWrite  in  1  from ctrl decoder
- regWrite  in  1  from ctrl decoder
- jctrl  in  1  from ctrl decoder, unconditional jump
- jrctrl  in  1  from ctrl decoder, jump register
- jalctrl  in  1  from ctrl decoder, jump-and-link
- beqctrl  in  1  from ctrl decoder, branch-if-equal
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory acknowledge, one-cycle pulse
- resume  in  1  leave HALT
- ir_load  out  1  load instruction register
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= target
- pc_src  out  2  00 immediate(j/jal), 01 register(jr), 10 branch offset(beq)
- mem_req  out  1  memory request, level
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  1  1 = PC drives address, 0 = ALU result
- alu_en  out  1  ALU result register enable
- reg_we  out  1  register-file write strobe
- state  out  3  current state encoding
- halted  out  1  high in HALT
- error  out  1  high in ERR
- retired  out  CNT_W  instructions retired

Behaviour:
- Reset (async, rst_n low): state=FETCH, all strobes 0, retired=0, wait counter=0, halted=0, error=0.
- All outputs other than state/halted/error/retired are Moore/registered-state decoded; no output depends combinationally on mem_ready except ir_load/pc_inc in FETCH.

State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.

- FETCH:
  - Outputs: mem_req=1, mem_we=0, addr_sel=1.
  - On mem_ready: ir_load=1 and pc_inc=1 in that same cycle; next DECODE.
- DECODE:
  - One cycle, no strobes; decoder settles.
  - opcode==HALT_OP -> HALT; else -> EXEC.
- EXEC:
  - One cycle, alu_en=1.
  - pc_load=1 if jctrl|jalctrl|jrctrl|(beqctrl&zero).
  - pc_src: jrctrl -> 01, beqctrl -> 10, else 00. Priority jrctrl > beqctrl > j/jal.
  - Next state:
    - memRead|memWrite -> MEM
    - else regWrite|jalctrl -> WB
    - else FETCH (retire)
- MEM:
  - Outputs: mem_req=1, mem_we=memWrite, addr_sel=0.
  - On mem_ready: memRead -> WB; else FETCH (retire).
- WB: reg_we=1 for exactly one cycle; next FETCH (retire).
- HALT:
  - halted=1, no strobes.
  - resume=1 -> FETCH; halt counts as retired on exit.
- ERR: error=1, sticky; leaves only via rst_n.

Watchdog:
- 8-bit wait counter cleared on entry to FETCH/MEM; increments each cycle with mem_req=1 and mem_ready=0.
- When counter reaches MEM_TIMEOUT-1 without mem_ready -> ERR next cycle.
- mem_ready arriving on the same cycle as the limit wins (normal transition).

Counter:
- retired increments by 1 on every transition into FETCH from EXEC/MEM/WB/HALT.
- Wraps modulo 2^CNT_W.

Other rules:
- Illegal state encoding (7) -> ERR.
- mem_ready outside FETCH/MEM is ignored.
- memRead and memWrite both set: treated as write (mem_we=1), then WB.
- rst_n asserted mid-transaction drops mem_req and all strobes immediately; no handshake completion is required.

Test Plan:
- ALU op (regWrite=1 only), mem_ready 2 cycles after request -> FETCH(3 cycles), DECODE, EXEC, WB; reg_we one cycle; retired 0->1.
- Load (memRead=1, regWrite=1) -> MEM with addr_sel=0, mem_we=0; reg_we after mem_ready; store (memWrite=1) -> mem_we=1, returns to FETCH with no reg_we.
- beqctrl=1, zero=1 -> pc_load=1, pc_src=10 in EXEC; zero=0 -> pc_load=0. jalctrl=1 -> pc_load=1, pc_src=00, then WB reg_we=1.
- opcode=4'hF -> halted=1 after DECODE; stays for 10 cycles; resume pulse -> FETCH, retired incremented.
- mem_ready withheld in FETCH -> error=1 exactly MEM_TIMEOUT cycles after request start; mem_ready on limit cycle -> no error.
- rst_n low mid-MEM -> mem_req=0 asynchronously, state=0, retired=0; retired wraps 16'hFFFF->0.
